// File: rtl/memmux_core.sv
// Two-bank memory mux: the writer master owns one bank while the reader owns the other, and swaps take a one-cycle turnaround.
// Define MEMMUX_READ_REG_EN to register mDATA_V, which adds 1 cycle of latency.
module memmux_core #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  switch,
  input  logic [ADDR_WIDTH-1:0] mADDR_M,
  input  logic [DATA_WIDTH-1:0] mDATA_M,
  input  logic                  mWE_M,
  input  logic [ADDR_WIDTH-1:0] mADDR_V,
  output logic [DATA_WIDTH-1:0] mDATA_V,
  output logic [ADDR_WIDTH-1:0] sADDR_A,
  inout  wire  [DATA_WIDTH-1:0] sDATA_A,
  output logic                  sWE_A,
  output logic [ADDR_WIDTH-1:0] sADDR_B,
  inout  wire  [DATA_WIDTH-1:0] sDATA_B,
  output logic                  sWE_B,
  output logic                  busy
);

  typedef enum logic {ST_RUN, ST_TURN} state_t;

  state_t                state;
  logic                  sel;
  logic                  turn;
  logic                  wrOn;
  logic [DATA_WIDTH-1:0] readBus;

  // A new request is sampled only in ST_RUN, so back-to-back swaps are at least 2 cycles apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      sel   <= 1'b0;
    end else begin
      case (state)
        ST_RUN:  if (switch != sel) begin
                   sel   <= switch;
                   state <= ST_TURN;
                 end
        ST_TURN: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  assign turn = (state == ST_TURN);
  assign busy = turn;
  assign wrOn = !rst && !turn;

  assign sADDR_A = sel ? mADDR_V : mADDR_M;
  assign sADDR_B = sel ? mADDR_M : mADDR_V;

  // The writer drives its bank only outside turnaround and reset, so the two banks are never driven at the same time.
  assign sDATA_A = (wrOn && !sel) ? mDATA_M : {DATA_WIDTH{1'bz}};
  assign sDATA_B = (wrOn &&  sel) ? mDATA_M : {DATA_WIDTH{1'bz}};
  assign sWE_A   = mWE_M && wrOn && !sel;
  assign sWE_B   = mWE_M && wrOn &&  sel;

  assign readBus = sel ? sDATA_A : sDATA_B;

`ifdef MEMMUX_READ_REG_EN
  logic [DATA_WIDTH-1:0] rdReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdReg <= '0;
    else if (!turn) rdReg <= readBus;
  end

  assign mDATA_V = rdReg;
`else
  assign mDATA_V = readBus;
`endif

endmodule

// File: tb/tb_memmux_core.sv
// Randomized self-checking bench for memmux_core, built around a cycle-level reference model of the bank mapping.
module tb_memmux_core;

  logic       clk = 1'b0;
  logic       rst, switch, mWE_M;
  logic [7:0] mADDR_M, mDATA_M, mADDR_V;
  logic [7:0] mDATA_V, sADDR_A, sADDR_B;
  logic       sWE_A, sWE_B, busy;
  wire  [7:0] sDATA_A, sDATA_B;

  // Stand-in for the memory side: the bench drives any bus that the DUT must leave undriven.
  logic       tbEnA, tbEnB;
  logic [7:0] tbDatA, tbDatB;
  assign sDATA_A = tbEnA ? tbDatA : 8'bz;
  assign sDATA_B = tbEnB ? tbDatB : 8'bz;

  memmux_core #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .switch(switch),
    .mADDR_M(mADDR_M), .mDATA_M(mDATA_M), .mWE_M(mWE_M),
    .mADDR_V(mADDR_V), .mDATA_V(mDATA_V),
    .sADDR_A(sADDR_A), .sDATA_A(sDATA_A), .sWE_A(sWE_A),
    .sADDR_B(sADDR_B), .sDATA_B(sDATA_B), .sWE_B(sWE_B),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: current mapping, turnaround flag and expected registered read data.
  logic       mSel  = 1'b0;
  logic       mTurn = 1'b0;
  logic [7:0] expRd = 8'h00;
  logic       prevBusy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs in mid-cycle, then advance the model across the rising edge.
  task automatic step(input logic rs, input logic sw, input logic [7:0] aM, input logic [7:0] dM,
                      input logic we, input logic [7:0] aV, input logic [7:0] pA, input logic [7:0] pB);
    logic       wrA, wrDrv;
    logic [7:0] rdVal;
    rst = rs; switch = sw; mADDR_M = aM; mDATA_M = dM; mWE_M = we; mADDR_V = aV;
    if (rs) begin
      mSel = 1'b0; mTurn = 1'b0; expRd = 8'h00;
    end
    wrA   = (mSel == 1'b0);
    wrDrv = !rs && !mTurn;
    tbEnA = !(wrA && wrDrv);
    tbEnB = !(!wrA && wrDrv);
    tbDatA = pA; tbDatB = pB;
    rdVal = mSel ? pA : pB;
    #2;
    chk("sADDR_A", sADDR_A, mSel ? aV : aM);
    chk("sADDR_B", sADDR_B, mSel ? aM : aV);
    chk("sDATA_A", sDATA_A, (wrA && wrDrv) ? dM : pA);
    chk("sDATA_B", sDATA_B, (!wrA && wrDrv) ? dM : pB);
    chk("sWE_A", sWE_A, we && wrDrv && wrA);
    chk("sWE_B", sWE_B, we && wrDrv && !wrA);
    chk("busy", busy, mTurn);
`ifdef MEMMUX_READ_REG_EN
    chk("mDATA_V", mDATA_V, expRd);
`else
    chk("mDATA_V", mDATA_V, rdVal);
`endif
    chk("busy2", busy && prevBusy, 1'b0);
    prevBusy = busy;
    @(posedge clk);
    #1;
    if (rs) expRd = 8'h00;
    else if (!mTurn) expRd = rdVal;
    if (rs) begin
      mSel = 1'b0; mTurn = 1'b0;
    end else if (mTurn) begin
      mTurn = 1'b0;
    end else if (sw != mSel) begin
      mSel = sw; mTurn = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; switch = 1'b0; mWE_M = 1'b0;
    mADDR_M = '0; mDATA_M = '0; mADDR_V = '0;
    tbEnA = 1'b0; tbEnB = 1'b0; tbDatA = '0; tbDatB = '0;

    // Reset state and the directed sequence: writer on A, then a swap 0->1.
    step(1, 0, 8'h12, 8'h34, 1, 8'h56, 8'h77, 8'h88);
    step(1, 1, 8'h21, 8'h43, 1, 8'h65, 8'h66, 8'h99);
    step(0, 0, 8'hFF, 8'hAA, 1, 8'hAA, 8'h3C, 8'h55);
    step(0, 0, 8'hFF, 8'hAA, 1, 8'hAA, 8'h3C, 8'h55);
    step(0, 1, 8'hFF, 8'hAA, 1, 8'hAA, 8'h3C, 8'h55);
    step(0, 1, 8'hAA, 8'hAA, 1, 8'hFF, 8'h5A, 8'hA5);
    step(0, 1, 8'hAA, 8'hAA, 1, 8'hFF, 8'h55, 8'hC3);
    step(0, 1, 8'hAA, 8'hAA, 1, 8'hFF, 8'h99, 8'hC3);
    step(0, 1, 8'hAA, 8'hAA, 1, 8'hFF, 8'h99, 8'hC3);

    // Reset while busy: swap back to 0, then assert rst during the turnaround.
    step(0, 0, 8'h10, 8'h20, 1, 8'h30, 8'h40, 8'h50);
    step(1, 0, 8'h11, 8'h21, 1, 8'h31, 8'h41, 8'h51);
    step(0, 0, 8'h12, 8'h22, 1, 8'h32, 8'h42, 8'h52);
    step(0, 1, 8'h13, 8'h23, 1, 8'h33, 8'h43, 8'h53);

    // Toggle switch every cycle while addresses ramp across the swaps.
    for (int i = 0; i < 40; i++)
      step(0, i[0], 8'(i), 8'($urandom), 1'($urandom), 8'(8'h80 + i), 8'($urandom), 8'($urandom));

    // Fully random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 29) == 0), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
